mem_burst_tester: RTL and testbench
===================================

# mem_burst_tester

Parametrised memory exercise sequencer for the Mem test path. It captures a base address, a base data word and a burst length from the operand input on successive clocks. It then issues a burst of writes and a read-back burst of the same addresses, and compares every returned word against the expected pattern. Write data follows one of four address/data modes, memory beats are gated by an acknowledge handshake, and mismatches are counted for display.

## Interface
Parameters:
- DATA_W, 16, width of operand input, write/expected data and read data
- ADDR_W, 16, width of memory address
- LEN_W, 8, width of burst-length field and beat counter; burst = len+1 beats

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in  in  DATA_W  operand input (switches)
- mode  in  2  pattern mode, sampled in LEN state
- ack  in  1  memory beat acknowledge; ignored when control==00
- rdata  in  DATA_W  memory read data, valid in any cycle with control==10 and ack==1
- addr  out  ADDR_W  current beat address
- data  out  DATA_W  current write data / expected read data
- control  out  2  00 idle, 01 write, 10 read (11 never driven)
- increment  out  LEN_W  current beat index within burst
- err_count  out  LEN_W+1  mismatches in current run
- mismatch  out  1  one-cycle pulse after a failing read beat
- done  out  1  one-cycle pulse at end of run

## Operation
- States: ADDR, DATA, LEN, WRITE, READ, DONE. All outputs are registered and change on the same edge as state.
- ADDR: at the edge, base_addr <= in, addr <= in.
  - If ADDR_W > DATA_W, the value is zero-extended; if narrower, it is truncated.
  - Next state is DATA.
- DATA: at the edge, base_data <= in, data <= in. Next state is LEN.
- LEN: at the edge:
  - len <= in[LEN_W-1:0], mode_r <= mode.
  - err_count <= 0, increment <= 0.
  - addr <= base_addr, data <= base_data.
  - control <= 01.
  - Next state is WRITE.
- WRITE: a beat completes on an edge with ack=1. Otherwise all outputs hold.
  - If increment==len: next state is READ, increment <= 0, addr <= base_addr, data <= pattern(0), control <= 10.
  - Otherwise: increment+1, with addr and data advanced per mode.
- READ: a beat completes on an edge with ack=1.
  - rdata is compared with data. If unequal, err_count += 1 and mismatch <= 1 for the next cycle.
  - If increment==len: next state is DONE, control <= 00, done <= 1.
  - Otherwise: advance as in WRITE.
- DONE: lasts exactly one cycle. done and control return to 00/0, increment <= 0. Next state is ADDR.
  - addr, data and err_count hold until the next LEN.
- Pattern for beat i (i = increment), with base values B (address) and D (data):
  - mode 00: addr=B, data=D on every beat.
  - mode 01: addr=B+i, data=D.
  - mode 10: addr=B+i, data=D+i.
  - mode 11: addr=B+i, data=D for even i, ~D for odd i.
- Arithmetic: addr wraps modulo 2^ADDR_W. data wraps modulo 2^DATA_W. i is zero-extended before adding.
- err_count cannot overflow, since the maximum is 2^LEN_W, which fits in LEN_W+1 bits.
- mode and len are ignored outside the LEN state. Changing them mid-run has no effect.

## Timing
- Reset (rst=0, asynchronous):
  - state=ADDR.
  - addr, data, increment, err_count = 0.
  - control=00, mismatch=0, done=0.
  - Takes effect immediately, including mid-burst. Release is sampled on the next rising edge.
- Setup: 3 edges (ADDR, DATA, LEN). control=01 is visible after the 3rd edge.
- With ack tied high, a run takes 3 + 2·(len+1) + 1 cycles from leaving reset to re-entering ADDR.
- ack low stalls the beat indefinitely. control, addr, data and increment stay stable while stalled.
- The last write beat and the first read beat are back-to-back. There is no idle cycle between bursts.
- mismatch is asserted on the cycle after the failing ack edge. Consecutive failing beats hold mismatch high continuously.
- err_count updates on the same edge as the failing beat.
- len=0 gives a single-beat burst. The WRITE→READ and READ→DONE transitions occur on the first ack.

## Test plan
- Reset mid-WRITE (pull rst low with increment=3) -> all outputs 0 and control=00 immediately; after release, state resumes at ADDR (next edge loads addr).
- Mode 10, in sequence 0x0100/0x1000/3, ack=1, memory model echoes -> writes to 0x0100..0x0103 with data 0x1000..0x1003, then reads of the same addresses; err_count=0, done pulse at cycle 12.
- Mode 11, len=3, memory model corrupts the beat-2 read (returns 0x0000 instead of D=0xA5A5) -> mismatch pulse on one cycle, err_count=1; expected data sequence A5A5,5A5A,A5A5,5A5A.
- Mode 01, base addr 0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap); mode 00, len=2 -> addr constant for all 6 beats.
- ack held low for 5 cycles during a read beat -> control=10 and addr/data/increment stable throughout; beat completes on the first ack=1 edge; len=0 run -> exactly 1 write and 1 read.
- Parameter sweep DATA_W=8, ADDR_W=12, LEN_W=4, len=15, mode 10, base data 0xF8 -> data wraps 0xF8..0xFF,0x00..0x07; err_count reaches 16 when the memory returns a constant 0xEE.

Source files
------------

// File: rtl/mem_burst_tester.sv
// Memory exercise sequencer: captures base address, base data and burst length,
// then writes a patterned burst and reads it back, counting miscompares.
module mem_burst_tester #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        mode,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        control,
  output logic [LEN_W-1:0]  increment,
  output logic [LEN_W:0]    err_count,
  output logic              mismatch,
  output logic              done
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_LEN,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'b00,
    CTL_WRITE = 2'b01,
    CTL_READ  = 2'b10
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   control_q, control_nxt;

  logic [ADDR_W-1:0] base_addr, base_addr_nxt;
  logic [DATA_W-1:0] base_data, base_data_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [1:0]        mode_r, mode_r_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [LEN_W-1:0]  inc_q, inc_nxt;
  logic [LEN_W:0]    err_q, err_nxt;
  logic              mismatch_q, mismatch_nxt;
  logic              done_q, done_nxt;

  logic             last_beat;
  logic             read_fail;
  logic [LEN_W-1:0] inc_plus1;

  // Beat address: mode 00 stays at the base, all other modes walk upward.
  function automatic logic [ADDR_W-1:0] pat_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [1:0]        m,
                                                 input logic [LEN_W-1:0]  i);
    return (m == 2'b00) ? b : b + ADDR_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] pat_data(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        m,
                                                 input logic [LEN_W-1:0]  i);
    logic [DATA_W-1:0] r;
    case (m)
      2'b10:   r = d + DATA_W'(i);
      2'b11:   r = i[0] ? ~d : d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign last_beat = (inc_q == len);
  assign inc_plus1 = inc_q + LEN_W'(1);
  assign read_fail = (state == S_READ) && ack && (rdata != data_q);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ADDR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  state_nxt = S_LEN;
      S_LEN:   state_nxt = S_WRITE;
      S_WRITE: if (ack && last_beat) state_nxt = S_READ;
      S_READ:  if (ack && last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_ADDR;
      default: state_nxt = S_ADDR;
    endcase
  end

  // NOTE: every value written here gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    base_addr_nxt = base_addr;
    base_data_nxt = base_data;
    len_nxt       = len;
    mode_r_nxt    = mode_r;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    control_nxt   = control_q;
    inc_nxt       = inc_q;
    err_nxt       = err_q;
    mismatch_nxt  = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      S_ADDR: begin
        base_addr_nxt = ADDR_W'(in);
        addr_nxt      = ADDR_W'(in);
      end
      S_DATA: begin
        base_data_nxt = in;
        data_nxt      = in;
      end
      S_LEN: begin
        len_nxt     = LEN_W'(in);
        mode_r_nxt  = mode;
        err_nxt     = '0;
        inc_nxt     = '0;
        addr_nxt    = base_addr;
        data_nxt    = base_data;
        control_nxt = CTL_WRITE;
      end
      S_WRITE: begin
        if (ack) begin
          if (last_beat) begin
            inc_nxt     = '0;
            addr_nxt    = base_addr;
            data_nxt    = pat_data(base_data, mode_r, '0);
            control_nxt = CTL_READ;
          end else begin
            inc_nxt  = inc_plus1;
            addr_nxt = pat_addr(base_addr, mode_r, inc_plus1);
            data_nxt = pat_data(base_data, mode_r, inc_plus1);
          end
        end
      end
      S_READ: begin
        if (ack) begin
          if (read_fail) begin
            err_nxt      = err_q + (LEN_W + 1)'(1);
            mismatch_nxt = 1'b1;
          end
          if (last_beat) begin
            control_nxt = CTL_IDLE;
            done_nxt    = 1'b1;
          end else begin
            inc_nxt  = inc_plus1;
            addr_nxt = pat_addr(base_addr, mode_r, inc_plus1);
            data_nxt = pat_data(base_data, mode_r, inc_plus1);
          end
        end
      end
      S_DONE: begin
        control_nxt = CTL_IDLE;
        inc_nxt     = '0;
      end
      default: begin
        control_nxt = CTL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_addr  <= '0;
      base_data  <= '0;
      len        <= '0;
      mode_r     <= 2'b00;
      addr_q     <= '0;
      data_q     <= '0;
      control_q  <= CTL_IDLE;
      inc_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      base_addr  <= base_addr_nxt;
      base_data  <= base_data_nxt;
      len        <= len_nxt;
      mode_r     <= mode_r_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      control_q  <= control_nxt;
      inc_q      <= inc_nxt;
      err_q      <= err_nxt;
      mismatch_q <= mismatch_nxt;
      done_q     <= done_nxt;
    end
  end

  assign addr      = addr_q;
  assign data      = data_q;
  assign control   = control_q;
  assign increment = inc_q;
  assign err_count = err_q;
  assign mismatch  = mismatch_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_burst_tester.sv
// Directed bench for mem_burst_tester: default-width instance plus a narrow
// 8/12/4 instance sharing clock, reset and control stimulus.
module tb_mem_burst_tester;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [1:0]  mode;
  logic        ack;

  logic [15:0] rdata_a;
  logic [15:0] addr_a;
  logic [15:0] data_a;
  logic [1:0]  control_a;
  logic [7:0]  increment_a;
  logic [8:0]  err_count_a;
  logic        mismatch_a;
  logic        done_a;

  logic [7:0]  rdata_b;
  logic [11:0] addr_b;
  logic [7:0]  data_b;
  logic [1:0]  control_b;
  logic [3:0]  increment_b;
  logic [4:0]  err_count_b;
  logic        mismatch_b;
  logic        done_b;

  int checks = 0;
  int errors = 0;

  mem_burst_tester dut_a (
    .clk(clk), .rst(rst), .in(in), .mode(mode), .ack(ack), .rdata(rdata_a),
    .addr(addr_a), .data(data_a), .control(control_a), .increment(increment_a),
    .err_count(err_count_a), .mismatch(mismatch_a), .done(done_a)
  );

  mem_burst_tester #(.DATA_W(8), .ADDR_W(12), .LEN_W(4)) dut_b (
    .clk(clk), .rst(rst), .in(in[7:0]), .mode(mode), .ack(ack), .rdata(rdata_b),
    .addr(addr_b), .data(data_b), .control(control_b), .increment(increment_b),
    .err_count(err_count_b), .mismatch(mismatch_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ack = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] l, input logic [1:0] m);
    in = a;
    tick();
    in = d;
    tick();
    in   = l;
    mode = m;
    tick();
  endtask

  // Checks the beat currently presented by instance A, supplies read data, completes it.
  task automatic beat_a(input string tag, input logic [1:0] ctl, input logic [15:0] a,
                        input logic [15:0] d, input logic [7:0] inc, input logic mis,
                        input logic [8:0] err, input logic [15:0] rd);
    check({tag, "_ctl"}, control_a, ctl);
    check({tag, "_addr"}, addr_a, a);
    check({tag, "_data"}, data_a, d);
    check({tag, "_inc"}, increment_a, inc);
    check({tag, "_mis"}, mismatch_a, mis);
    check({tag, "_err"}, err_count_a, err);
    check({tag, "_done"}, done_a, 1'b0);
    rdata_a = rd;
    ack     = 1'b1;
    tick();
  endtask

  task automatic beat_b(input string tag, input logic [1:0] ctl, input logic [11:0] a,
                        input logic [7:0] d, input logic [3:0] inc, input logic mis,
                        input logic [4:0] err);
    check({tag, "_ctl"}, control_b, ctl);
    check({tag, "_addr"}, addr_b, a);
    check({tag, "_data"}, data_b, d);
    check({tag, "_inc"}, increment_b, inc);
    check({tag, "_mis"}, mismatch_b, mis);
    check({tag, "_err"}, err_count_b, err);
    rdata_b = 8'hEE;
    ack     = 1'b1;
    tick();
  endtask

  // Checks the DONE cycle of instance A, then steps back into ADDR.
  task automatic finish_a(input string tag, input logic [8:0] err, input logic mis);
    check({tag, "_done1"}, done_a, 1'b1);
    check({tag, "_ctl_done"}, control_a, 2'b00);
    check({tag, "_err_done"}, err_count_a, err);
    check({tag, "_mis_done"}, mismatch_a, mis);
    tick();
    check({tag, "_done0"}, done_a, 1'b0);
    check({tag, "_ctl_idle"}, control_a, 2'b00);
    check({tag, "_inc_idle"}, increment_a, 8'd0);
    check({tag, "_err_hold"}, err_count_a, err);
    check({tag, "_mis_idle"}, mismatch_a, 1'b0);
  endtask

  logic [15:0] wrap_addr [4];
  logic [15:0] alt_data  [4];

  initial begin
    rst = 1'b0; in = '0; mode = 2'b00; ack = 1'b0; rdata_a = '0; rdata_b = '0;
    wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
    wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
    alt_data[0] = 16'hA5A5; alt_data[1] = 16'h5A5A;
    alt_data[2] = 16'hA5A5; alt_data[3] = 16'h5A5A;

    // Reset state.
    #1;
    check("rst_addr", addr_a, 16'h0000);
    check("rst_data", data_a, 16'h0000);
    check("rst_ctl", control_a, 2'b00);
    check("rst_inc", increment_a, 8'd0);
    check("rst_err", err_count_a, 9'd0);
    check("rst_mis", mismatch_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    do_reset();

    // Reset asserted mid-WRITE takes effect without a clock edge.
    setup(16'h0200, 16'h3000, 16'd7, 2'b10);
    ack = 1'b1;
    tick(); tick(); tick();
    check("mid_inc", increment_a, 8'd3);
    check("mid_addr", addr_a, 16'h0203);
    check("mid_data", data_a, 16'h3003);
    check("mid_ctl", control_a, 2'b01);
    #2 rst = 1'b0;
    #1;
    check("async_addr", addr_a, 16'h0000);
    check("async_data", data_a, 16'h0000);
    check("async_ctl", control_a, 2'b00);
    check("async_inc", increment_a, 8'd0);
    tick();
    rst = 1'b1; ack = 1'b0; in = 16'h4444;
    tick();
    check("resume_addr", addr_a, 16'h4444);
    check("resume_ctl", control_a, 2'b00);

    // Mode 10, echoing memory; done visible after edge 11.
    do_reset();
    setup(16'h0100, 16'h1000, 16'd3, 2'b10);
    for (int i = 0; i < 4; i++)
      beat_a("m10_wr", 2'b01, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 8'(i), 1'b0, 9'd0, 16'h0000);
    for (int i = 0; i < 4; i++)
      beat_a("m10_rd", 2'b10, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 8'(i), 1'b0, 9'd0,
             16'h1000 + 16'(i));
    finish_a("m10", 9'd0, 1'b0);

    // Mode 11, beat 2 read corrupted.
    setup(16'h0040, 16'hA5A5, 16'd3, 2'b11);
    for (int i = 0; i < 4; i++)
      beat_a("m11_wr", 2'b01, 16'h0040 + 16'(i), alt_data[i], 8'(i), 1'b0, 9'd0, 16'h0000);
    beat_a("m11_rd0", 2'b10, 16'h0040, 16'hA5A5, 8'd0, 1'b0, 9'd0, 16'hA5A5);
    beat_a("m11_rd1", 2'b10, 16'h0041, 16'h5A5A, 8'd1, 1'b0, 9'd0, 16'h5A5A);
    beat_a("m11_rd2", 2'b10, 16'h0042, 16'hA5A5, 8'd2, 1'b0, 9'd0, 16'h0000);
    beat_a("m11_rd3", 2'b10, 16'h0043, 16'h5A5A, 8'd3, 1'b1, 9'd1, 16'h5A5A);
    finish_a("m11", 9'd1, 1'b0);

    // Mode 01 with address wrap.
    setup(16'hFFFE, 16'h1234, 16'd3, 2'b01);
    for (int i = 0; i < 4; i++)
      beat_a("m01_wr", 2'b01, wrap_addr[i], 16'h1234, 8'(i), 1'b0, 9'd0, 16'h0000);
    for (int i = 0; i < 4; i++)
      beat_a("m01_rd", 2'b10, wrap_addr[i], 16'h1234, 8'(i), 1'b0, 9'd0, 16'h1234);
    finish_a("m01", 9'd0, 1'b0);

    // Mode 00: address constant across all six beats.
    setup(16'h0777, 16'hBEEF, 16'd2, 2'b00);
    for (int i = 0; i < 3; i++)
      beat_a("m00_wr", 2'b01, 16'h0777, 16'hBEEF, 8'(i), 1'b0, 9'd0, 16'h0000);
    for (int i = 0; i < 3; i++)
      beat_a("m00_rd", 2'b10, 16'h0777, 16'hBEEF, 8'(i), 1'b0, 9'd0, 16'hBEEF);
    finish_a("m00", 9'd0, 1'b0);

    // ack held low during the first read beat.
    setup(16'h0300, 16'h0050, 16'd1, 2'b10);
    beat_a("stl_wr0", 2'b01, 16'h0300, 16'h0050, 8'd0, 1'b0, 9'd0, 16'h0000);
    beat_a("stl_wr1", 2'b01, 16'h0301, 16'h0051, 8'd1, 1'b0, 9'd0, 16'h0000);
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stl_ctl", control_a, 2'b10);
      check("stl_addr", addr_a, 16'h0300);
      check("stl_data", data_a, 16'h0050);
      check("stl_inc", increment_a, 8'd0);
    end
    beat_a("stl_rd0", 2'b10, 16'h0300, 16'h0050, 8'd0, 1'b0, 9'd0, 16'h0050);
    beat_a("stl_rd1", 2'b10, 16'h0301, 16'h0051, 8'd1, 1'b0, 9'd0, 16'h0051);
    finish_a("stl", 9'd0, 1'b0);

    // len=0: one write, one read.
    setup(16'h0900, 16'h0077, 16'd0, 2'b01);
    beat_a("len0_wr", 2'b01, 16'h0900, 16'h0077, 8'd0, 1'b0, 9'd0, 16'h0000);
    beat_a("len0_rd", 2'b10, 16'h0900, 16'h0077, 8'd0, 1'b0, 9'd0, 16'h0077);
    finish_a("len0", 9'd0, 1'b0);

    // Narrow instance: data wraps 0xF8..0x07, constant 0xEE read data fails all 16.
    do_reset();
    setup(16'h0ABC, 16'h00F8, 16'h000F, 2'b10);
    for (int i = 0; i < 16; i++)
      beat_b("nb_wr", 2'b01, 12'h0BC + 12'(i), 8'hF8 + 8'(i), 4'(i), 1'b0, 5'd0);
    for (int i = 0; i < 16; i++)
      beat_b("nb_rd", 2'b10, 12'h0BC + 12'(i), 8'hF8 + 8'(i), 4'(i), (i > 0), 5'(i));
    check("nb_done", done_b, 1'b1);
    check("nb_err", err_count_b, 5'h10);
    check("nb_mis", mismatch_b, 1'b1);
    check("nb_ctl", control_b, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
